// File: rtl/rf_read_arbiter_pkg.sv
// Shared definitions for the register-file read-port arbiter.
//
// Contents:
//   - Select codes driven on rs_sel: ADD=00, MULT=01, MULADD=10. Code 11 is never used.
//     The rs1/rs2 operand muxes decode these same values.
//   - next_ptr(): modulo-3 successor used for round-robin rotation (MULADD wraps to ADD).
package rf_read_arbiter_pkg;

  localparam logic [1:0] SelAdd    = 2'b00;
  localparam logic [1:0] SelMult   = 2'b01;
  localparam logic [1:0] SelMuladd = 2'b10;

  localparam int unsigned NumReq = 3;

  // Successor in the cyclic order ADD -> MULT -> MULADD -> ADD. The unused code 11
  // maps to ADD so a corrupted pointer recovers on its next update.
  function automatic logic [1:0] next_ptr(input logic [1:0] cur);
    logic [1:0] nxt;
    unique case (cur)
      SelAdd:    nxt = SelMult;
      SelMult:   nxt = SelMuladd;
      SelMuladd: nxt = SelAdd;
      default:   nxt = SelAdd;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker.
//
// Ports:
//   req    [2:0] in   request vector, bit index equals the requester's select code
//   ptr    [1:0] in   highest-priority requester for this pick
//   valid        out  at least one request is present
//   winner [1:0] out  select code of the first requester found from ptr onwards
//                     (ADD when valid is low)
module rr_pick3
  import rf_read_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] winner
);

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  always_comb begin
    // Treat an illegal pointer as ADD so indexing below stays within req.
    cand0  = (ptr == 2'b11) ? SelAdd : ptr;
    cand1  = next_ptr(cand0);
    cand2  = next_ptr(cand1);
    valid  = |req;
    winner = SelAdd;
    if (req[cand0]) begin
      winner = cand0;
    end else if (req[cand1]) begin
      winner = cand1;
    end else if (req[cand2]) begin
      winner = cand2;
    end
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter for the register-file read port shared by the ADD, MULT and
// MULADD execution controllers. One owner at a time; rs_sel stays stable for the
// whole ownership window plus one turnaround cycle. A stuck owner is released after
// MAX_HOLD cycles (0 disables the timeout).
//
// Ports:
//   clk                            in   system clock, rising edge
//   rst                            in   synchronous active-high reset
//   req_add/req_mult/req_muladd    in   level requests, held until granted
//   done_add/done_mult/done_muladd in   one-cycle release pulses from the owner
//   gnt_add/gnt_mult/gnt_muladd    out  one-hot grants (registered)
//   rs_sel [1:0]                   out  operand mux select of the most recent winner
//   busy                           out  arbiter is not idle
//   timeout                        out  one-cycle pulse on a forced release
module rf_read_arbiter
  import rf_read_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_add,
  input  logic       req_mult,
  input  logic       req_muladd,
  input  logic       done_add,
  input  logic       done_mult,
  input  logic       done_muladd,
  output logic       gnt_add,
  output logic       gnt_mult,
  output logic       gnt_muladd,
  output logic [1:0] rs_sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StGrant   = 2'b01,
    StRelease = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [NumReq-1:0]    gnt_q, gnt_d;
  logic [1:0]           rs_sel_q, rs_sel_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;

  logic [NumReq-1:0]    req_vec;
  logic [NumReq-1:0]    done_vec;
  logic                 pick_valid;
  logic [1:0]           pick_winner;
  logic                 owner_req;
  logic                 owner_done;
  logic                 hold_expired;

  assign req_vec  = {req_muladd, req_mult, req_add};
  assign done_vec = {done_muladd, done_mult, done_add};

  rr_pick3 u_pick (
    .req    (req_vec),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    // rs_sel_q holds the owner's code during GRANT; only the owner's signals matter.
    owner_req    = 1'b0;
    owner_done   = 1'b0;
    unique case (rs_sel_q)
      SelAdd: begin
        owner_req  = req_vec[0];
        owner_done = done_vec[0];
      end
      SelMult: begin
        owner_req  = req_vec[1];
        owner_done = done_vec[1];
      end
      SelMuladd: begin
        owner_req  = req_vec[2];
        owner_done = done_vec[2];
      end
      default: begin
        owner_req  = 1'b0;
        owner_done = 1'b0;
      end
    endcase

    hold_expired = (MAX_HOLD != 0) &&
                   (hold_cnt_q == CNT_WIDTH'(MAX_HOLD - 1));
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rs_sel_d   = rs_sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d    = StGrant;
          gnt_d      = NumReq'(1) << pick_winner;
          rs_sel_d   = pick_winner;
          hold_cnt_d = '0;
        end
      end

      StGrant: begin
        if (hold_cnt_q != {CNT_WIDTH{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + CNT_WIDTH'(1);
        end
        // A normal release wins over a coincident timeout, so timeout stays low then.
        if (owner_done || !owner_req) begin
          state_d = StRelease;
          gnt_d   = '0;
        end else if (hold_expired) begin
          state_d   = StRelease;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end
      end

      StRelease: begin
        // rs_sel is left untouched so the read address stays stable this cycle.
        state_d = StIdle;
        ptr_d   = next_ptr(rs_sel_q);
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      rs_sel_q   <= SelAdd;
      ptr_q      <= SelAdd;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rs_sel_q   <= rs_sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_add    = gnt_q[0];
  assign gnt_mult   = gnt_q[1];
  assign gnt_muladd = gnt_q[2];
  assign rs_sel     = rs_sel_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
module tb_rf_read_arbiter;

  logic       clk;
  logic       rst;
  logic       req_add, req_mult, req_muladd;
  logic       done_add, done_mult, done_muladd;
  logic       gnt_add, gnt_mult, gnt_muladd;
  logic [1:0] rs_sel;
  logic       busy;
  logic       timeout;

  int checks;
  int failures;

  rf_read_arbiter #(
    .MAX_HOLD  (4),
    .CNT_WIDTH (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_add     (req_add),
    .req_mult    (req_mult),
    .req_muladd  (req_muladd),
    .done_add    (done_add),
    .done_mult   (done_mult),
    .done_muladd (done_muladd),
    .gnt_add     (gnt_add),
    .gnt_mult    (gnt_mult),
    .gnt_muladd  (gnt_muladd),
    .rs_sel      (rs_sel),
    .busy        (busy),
    .timeout     (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // gnt is {muladd, mult, add}
  task automatic expect_out(input string tag, input logic [2:0] g, input logic [1:0] sel,
                            input logic b, input logic to);
    chk({tag, ".gnt"}, {1'b0, gnt_muladd, gnt_mult, gnt_add}, {1'b0, g});
    chk({tag, ".rs_sel"}, {2'b00, rs_sel}, {2'b00, sel});
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, b});
    chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, to});
  endtask

  task automatic set_done(input logic [1:0] code, input logic v);
    case (code)
      2'b00:   done_add = v;
      2'b01:   done_mult = v;
      default: done_muladd = v;
    endcase
  endtask

  initial begin
    logic [1:0] order [4];
    logic [2:0] onehot;
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    req_add     = 1'b0;
    req_mult    = 1'b0;
    req_muladd  = 1'b0;
    done_add    = 1'b0;
    done_mult   = 1'b0;
    done_muladd = 1'b0;
    order[0] = 2'b00;
    order[1] = 2'b01;
    order[2] = 2'b10;
    order[3] = 2'b00;

    // Reset state
    tick();
    tick();
    expect_out("reset", 3'b000, 2'b00, 1'b0, 1'b0);

    // Single MULT request: one-cycle grant latency, done -> RELEASE -> IDLE
    rst      = 1'b0;
    req_mult = 1'b1;
    tick();
    expect_out("mult_grant", 3'b010, 2'b01, 1'b1, 1'b0);
    tick();
    tick();
    expect_out("mult_hold", 3'b010, 2'b01, 1'b1, 1'b0);
    done_mult = 1'b1;
    tick();
    done_mult = 1'b0;
    req_mult  = 1'b0;
    expect_out("mult_release", 3'b000, 2'b01, 1'b1, 1'b0);
    tick();
    expect_out("mult_idle", 3'b000, 2'b01, 1'b0, 1'b0);

    // Reset so ptr restarts at ADD, then three-way contention
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("reset2", 3'b000, 2'b00, 1'b0, 1'b0);
    req_add    = 1'b1;
    req_mult   = 1'b1;
    req_muladd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      onehot = 3'b001 << order[k];
      tick();
      expect_out($sformatf("rr%0d_grant", k), onehot, order[k], 1'b1, 1'b0);
      tick();
      tick();
      set_done(order[k], 1'b1);
      tick();
      set_done(order[k], 1'b0);
      expect_out($sformatf("rr%0d_release", k), 3'b000, order[k], 1'b1, 1'b0);
      tick();
      expect_out($sformatf("rr%0d_idle", k), 3'b000, order[k], 1'b0, 1'b0);
    end
    req_add    = 1'b0;
    req_mult   = 1'b0;
    req_muladd = 1'b0;

    // Timeout: ADD holds with no done, gnt high exactly 4 cycles
    req_add = 1'b1;
    tick();
    expect_out("to_grant", 3'b001, 2'b00, 1'b1, 1'b0);
    for (int c = 1; c < 4; c++) begin
      tick();
      expect_out($sformatf("to_hold%0d", c), 3'b001, 2'b00, 1'b1, 1'b0);
    end
    tick();
    expect_out("to_pulse", 3'b000, 2'b00, 1'b1, 1'b1);
    tick();
    expect_out("to_idle", 3'b000, 2'b00, 1'b0, 1'b0);
    tick();
    expect_out("to_regrant", 3'b001, 2'b00, 1'b1, 1'b0);

    // done coincides with the last hold cycle: normal release, no timeout
    tick();
    tick();
    tick();
    expect_out("coinc_last", 3'b001, 2'b00, 1'b1, 1'b0);
    done_add = 1'b1;
    tick();
    done_add = 1'b0;
    req_add  = 1'b0;
    expect_out("coinc_release", 3'b000, 2'b00, 1'b1, 1'b0);
    tick();
    expect_out("coinc_idle", 3'b000, 2'b00, 1'b0, 1'b0);

    // MULADD owner ignores non-owner done/req
    req_muladd = 1'b1;
    tick();
    expect_out("md_grant", 3'b100, 2'b10, 1'b1, 1'b0);
    done_add  = 1'b1;
    done_mult = 1'b1;
    req_add   = 1'b1;
    tick();
    done_add  = 1'b0;
    done_mult = 1'b0;
    expect_out("md_ignore", 3'b100, 2'b10, 1'b1, 1'b0);
    done_muladd = 1'b1;
    tick();
    done_muladd = 1'b0;
    req_muladd  = 1'b0;
    req_add     = 1'b0;
    expect_out("md_release", 3'b000, 2'b10, 1'b1, 1'b0);
    tick();
    expect_out("md_idle", 3'b000, 2'b10, 1'b0, 1'b0);

    // Reset while MULT owns the port, then MULT beats MULADD from ptr=ADD
    req_mult = 1'b1;
    tick();
    expect_out("rst_pre", 3'b010, 2'b01, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("rst_mid", 3'b000, 2'b00, 1'b0, 1'b0);
    req_muladd = 1'b1;
    tick();
    expect_out("rst_after", 3'b010, 2'b01, 1'b1, 1'b0);

    // Owner dropping its request releases the port
    req_mult   = 1'b0;
    req_muladd = 1'b0;
    tick();
    expect_out("reqdrop_release", 3'b000, 2'b01, 1'b1, 1'b0);
    tick();
    expect_out("reqdrop_idle", 3'b000, 2'b01, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
